// File: rtl/fetch_unit_pkg.sv
// Shared sizes, state encodings and the instr/pc entry type for the fetch front end.
package fetch_unit_pkg;

    localparam int PC_WIDTH = 32;
    localparam int IWIDTH   = 32;
    localparam int DEPTH    = 256;
    localparam int PC_STEP  = 4;

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [IWIDTH-1:0]   instr;
        logic [PC_WIDTH-1:0] pc;
    } fetch_entry_t;

    function automatic logic [PC_WIDTH-1:0] word_align(input logic [PC_WIDTH-1:0] addr);
        return {addr[PC_WIDTH-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_skid.sv
// One-entry instr+pc holding buffer; clear takes priority over load.
module if_skid
    import fetch_unit_pkg::*;
(
    input  logic         if_clk,
    input  logic         if_rst,
    input  logic         load,
    input  logic         clear,
    input  fetch_entry_t din,
    output logic         valid,
    output fetch_entry_t entry
);

    always_ff @(posedge if_clk or negedge if_rst) begin
        if (!if_rst) begin
            valid <= 1'b0;
            entry <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            entry <= din;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues one imem word per cycle, and hands
// instr/pc pairs to decode through a one-entry skid with same-cycle redirect squash.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                if_clk,
    input  logic                if_rst,
    input  logic                if_i_stall,
    input  logic                if_i_redirect,
    input  logic [PC_WIDTH-1:0] if_i_redirect_pc,
    output logic                if_o_im_ce,
    output logic [PC_WIDTH-1:0] if_o_im_address,
    input  logic [IWIDTH-1:0]   if_i_im_instr,
    input  logic                if_i_im_ce,
    output logic                if_o_valid,
    output logic [IWIDTH-1:0]   if_o_instr,
    output logic [PC_WIDTH-1:0] if_o_pc
);

    fetch_state_e        state, state_nxt;
    logic [PC_WIDTH-1:0] fetch_pc, inflight_pc, issue_addr;
    logic                booting, redirect_eff, resp_live, issue;
    logic                skid_load, skid_clear, skid_valid;
    fetch_entry_t        skid_entry, resp_entry;

    // Boot gates redirect as well, so nothing reaches imem while it reloads.
    assign booting      = (state == S_BOOT);
    assign redirect_eff = if_i_redirect & ~booting;
    assign resp_live    = if_i_im_ce & ~redirect_eff & ~booting;
    assign issue        = redirect_eff | (~booting & ~if_i_stall);
    assign issue_addr   = redirect_eff ? word_align(if_i_redirect_pc) : fetch_pc;

    assign if_o_im_ce      = issue;
    assign if_o_im_address = issue_addr;

    assign skid_load  = (state == S_RUN) & if_i_stall & resp_live;
    assign skid_clear = redirect_eff | ((state == S_HOLD) & ~if_i_stall);
    assign resp_entry = '{instr: if_i_im_instr, pc: inflight_pc};

    if_skid u_skid (
        .if_clk (if_clk),
        .if_rst (if_rst),
        .load   (skid_load),
        .clear  (skid_clear),
        .din    (resp_entry),
        .valid  (skid_valid),
        .entry  (skid_entry)
    );

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_BOOT:  state_nxt = S_RUN;
            S_RUN:   if (skid_load) state_nxt = S_HOLD;
            S_HOLD:  if (!if_i_stall) state_nxt = S_RUN;
            default: state_nxt = S_BOOT;
        endcase
        if (redirect_eff) state_nxt = S_RUN;
    end

    always_ff @(posedge if_clk or negedge if_rst) begin
        if (!if_rst) begin
            state       <= S_BOOT;
            fetch_pc    <= word_align(RESET_PC);
            inflight_pc <= '0;
        end else begin
            state <= state_nxt;
            if (issue) begin
                inflight_pc <= issue_addr;
                fetch_pc    <= issue_addr + PC_WIDTH'(PC_STEP);
            end
        end
    end

    // Skid wins over the raw response; both are zeroed when nothing is live.
    always_comb begin
        if_o_valid = 1'b0;
        if_o_instr = '0;
        if_o_pc    = '0;
        if (!redirect_eff) begin
            if (skid_valid) begin
                if_o_valid = 1'b1;
                if_o_instr = skid_entry.instr;
                if_o_pc    = skid_entry.pc;
            end else if (resp_live) begin
                if_o_valid = 1'b1;
                if_o_instr = if_i_im_instr;
                if_o_pc    = inflight_pc;
            end
        end
    end

    a_skid_no_overflow: assert property (@(posedge if_clk) disable iff (!if_rst)
        !(skid_valid && resp_live && if_i_stall));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit against a registered one-cycle imem model.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam int IDXW = $clog2(DEPTH);

    logic                if_clk, if_rst;
    logic                stall, redirect;
    logic [PC_WIDTH-1:0] redirect_pc;
    logic                im_ce_req, im_ce_rsp;
    logic [PC_WIDTH-1:0] im_addr;
    logic [IWIDTH-1:0]   im_instr;
    logic                o_valid;
    logic [IWIDTH-1:0]   o_instr;
    logic [PC_WIDTH-1:0] o_pc;
    logic [IWIDTH-1:0]   mem [DEPTH];

    int checks   = 0;
    int failures = 0;

    fetch_unit #(.RESET_PC('0)) dut (
        .if_clk           (if_clk),
        .if_rst           (if_rst),
        .if_i_stall       (stall),
        .if_i_redirect    (redirect),
        .if_i_redirect_pc (redirect_pc),
        .if_o_im_ce       (im_ce_req),
        .if_o_im_address  (im_addr),
        .if_i_im_instr    (im_instr),
        .if_i_im_ce       (im_ce_rsp),
        .if_o_valid       (o_valid),
        .if_o_instr       (o_instr),
        .if_o_pc          (o_pc)
    );

    initial if_clk = 1'b0;
    always #5 if_clk = ~if_clk;

    // imem word i holds 0x1000_0000 + i
    initial for (int i = 0; i < DEPTH; i++) mem[i] = 32'h1000_0000 + i;

    always @(posedge if_clk or negedge if_rst) begin
        if (!if_rst) begin
            im_ce_rsp <= 1'b0;
            im_instr  <= '0;
        end else begin
            im_ce_rsp <= im_ce_req;
            if (im_ce_req) im_instr <= mem[im_addr[IDXW+1:2]];
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic s, input logic r, input logic [PC_WIDTH-1:0] rpc);
        @(posedge if_clk);
        #1;
        stall       = s;
        redirect    = r;
        redirect_pc = rpc;
        #1;
    endtask

    task automatic req(input string t, input logic ce, input logic [PC_WIDTH-1:0] a);
        chk({t, "_ce"}, 64'(im_ce_req), 64'(ce));
        chk({t, "_addr"}, 64'(im_addr), 64'(a));
    endtask

    task automatic out(input string t, input logic v, input logic [PC_WIDTH-1:0] pc,
                       input logic [IWIDTH-1:0] ins);
        chk({t, "_valid"}, 64'(o_valid), 64'(v));
        chk({t, "_pc"}, 64'(o_pc), 64'(pc));
        chk({t, "_instr"}, 64'(o_instr), 64'(ins));
    endtask

    initial begin
        if_rst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        repeat (2) @(posedge if_clk);
        #1;
        req("rst", 1'b0, 32'h0);
        out("rst", 1'b0, 32'h0, 32'h0);
        if_rst = 1'b1;
        #1;
        req("boot", 1'b0, 32'h0);
        out("boot", 1'b0, 32'h0, 32'h0);

        drive(0, 0, 0); req("c1", 1, 32'h0);  out("c1", 0, 32'h0, 32'h0);
        drive(0, 0, 0); req("c2", 1, 32'h4);  out("c2", 1, 32'h0, 32'h1000_0000);
        drive(0, 0, 0); req("c3", 1, 32'h8);  out("c3", 1, 32'h4, 32'h1000_0001);

        // stall three cycles with pc 8 returning
        drive(1, 0, 0); req("st0", 0, 32'hC); out("st0", 1, 32'h8, 32'h1000_0002);
        drive(1, 0, 0); req("st1", 0, 32'hC); out("st1", 1, 32'h8, 32'h1000_0002);
        drive(1, 0, 0); req("st2", 0, 32'hC); out("st2", 1, 32'h8, 32'h1000_0002);
        drive(0, 0, 0); req("rel", 1, 32'hC); out("rel", 1, 32'h8, 32'h1000_0002);
        drive(0, 0, 0); req("r12", 1, 32'h10); out("r12", 1, 32'hC, 32'h1000_0003);

        // redirect while 0x10 in flight
        drive(0, 1, 32'h40); req("rd", 1, 32'h40); out("rd", 0, 32'h0, 32'h0);
        drive(0, 0, 0); req("rd1", 1, 32'h44); out("rd1", 1, 32'h40, 32'h1000_0010);

        // redirect with skid full under stall
        drive(1, 0, 0); req("sk", 0, 32'h48); out("sk", 1, 32'h44, 32'h1000_0011);
        drive(1, 1, 32'h40); req("skrd", 1, 32'h40); out("skrd", 0, 32'h0, 32'h0);
        drive(0, 0, 0); req("skrd1", 1, 32'h44); out("skrd1", 1, 32'h40, 32'h1000_0010);

        // unaligned target, then wrap at the top of the address space
        drive(0, 1, 32'h23); req("ua", 1, 32'h20); out("ua", 0, 32'h0, 32'h0);
        drive(0, 0, 0); req("ua1", 1, 32'h24); out("ua1", 1, 32'h20, 32'h1000_0008);
        drive(0, 1, 32'hFFFF_FFFF); req("mx", 1, 32'hFFFF_FFFC); out("mx", 0, 32'h0, 32'h0);
        drive(0, 0, 0); req("mx1", 1, 32'h0); out("mx1", 1, 32'hFFFF_FFFC, 32'h1000_00FF);
        drive(0, 0, 0); req("mx2", 1, 32'h4); out("mx2", 1, 32'h0, 32'h1000_0000);

        // async reset mid-stream
        #1;
        if_rst = 1'b0;
        #1;
        req("arst", 0, 32'h0);
        out("arst", 0, 32'h0, 32'h0);
        @(posedge if_clk);
        #1;
        if_rst = 1'b1;
        #1;
        req("aboot", 0, 32'h0); out("aboot", 0, 32'h0, 32'h0);
        drive(0, 0, 0); req("a1", 1, 32'h0); out("a1", 0, 32'h0, 32'h0);
        drive(0, 0, 0); req("a2", 1, 32'h4); out("a2", 1, 32'h0, 32'h1000_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
